dmem_responder: RTL



---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_array.sv | 22 ++
 rtl/dmem_responder.sv | 115 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and geometry for the data-memory responder.
package dmem_pkg;

  localparam int LINE_W = 256;
  localparam int DEPTH  = 512;
  localparam int IDX_W  = 9;
  localparam int OFS_W  = 5;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

  // Line index of a byte address; high bits alias modulo DEPTH lines.
  function automatic logic [IDX_W-1:0] line_idx(input logic [31:0] addr);
    return addr[OFS_W +: IDX_W];
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port line store: synchronous write, synchronous read on a strobe, no reset.
module dmem_array #(
  parameter int LINE_W = 256,
  parameter int DEPTH  = 512,
  parameter int IDX_W  = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] memory [DEPTH];

  always_ff @(posedge clk) begin
    if (we) memory[idx] <= wdata;
    if (re) rdata <= memory[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Line-fill / write-back responder: one request at a time, fixed latency, one-cycle ack.
// Optional sticky protocol checker enabled by DMEM_PROTOCOL_CHECK_EN.
module dmem_responder #(
  parameter int LINE_W  = dmem_pkg::LINE_W,
  parameter int DEPTH   = dmem_pkg::DEPTH,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o,
  output logic              proto_err_o
);
  import dmem_pkg::*;

  state_e            state, state_nxt;
  logic [7:0]        cnt;
  logic [IDX_W-1:0]  req_idx;
  logic [LINE_W-1:0] req_data;
  logic              req_wr;
  logic              rd_seen;
  logic [LINE_W-1:0] rd_data;
  logic              accept, done;
  logic              unused_addr;

  assign unused_addr = ^{addr_i[31:14], addr_i[4:0]};
  assign accept = (state == IDLE) && enable_i;
  // Counter runs LATENCY-1 .. 0 in WAIT, so the access lands on edge accept+LATENCY.
  assign done   = (state == WAIT) && (cnt == 8'd0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable_i) state_nxt = WAIT;
      WAIT:    if (cnt == 8'd0) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt      <= '0;
      req_idx  <= '0;
      req_data <= '0;
      req_wr   <= 1'b0;
      ack_o    <= 1'b0;
      busy_o   <= 1'b0;
      rd_seen  <= 1'b0;
    end else begin
      if (accept) begin
        cnt      <= 8'(LATENCY - 1);
        req_idx  <= line_idx(addr_i);
        req_data <= data_i;
        req_wr   <= write_i;
      end else if (state == WAIT && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
      ack_o  <= (state_nxt == ACK);
      busy_o <= (state_nxt != IDLE);
      if (done && !req_wr) rd_seen <= 1'b1;
    end
  end

  // Array read register has no reset; mask it until the first read after reset.
  assign data_o = rd_seen ? rd_data : '0;

  dmem_array #(.LINE_W(LINE_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dmem_array (
    .clk   (clk_i),
    .we    (done && req_wr && rst_i),
    .re    (done && !req_wr),
    .idx   (req_idx),
    .wdata (req_data),
    .rdata (rd_data)
  );

`ifdef DMEM_PROTOCOL_CHECK_EN
  logic       proto_err;
  logic [3:0] viol;

  assign viol = {!enable_i, line_idx(addr_i) != req_idx,
                 write_i != req_wr, data_i != req_data};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                          proto_err <= 1'b0;
    else if (state == WAIT && |viol)     proto_err <= 1'b1;
  end
  assign proto_err_o = proto_err;

`ifndef SYNTHESIS
  logic [31:0] cyc_cnt;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cyc_cnt <= '0;
    else        cyc_cnt <= cyc_cnt + 32'd1;
  end
  always @(posedge clk_i)
    if (rst_i && state == WAIT && |viol)
      $display("dmem_responder: protocol violation at cycle %0d (enable=%b addr=%b write=%b data=%b)",
               cyc_cnt, viol[3], viol[2], viol[1], viol[0]);
`endif
`else
  assign proto_err_o = 1'b0;
`endif

endmodule
